// File: rtl/pcm_tdm_rx_pkg.sv
// pcm_tdm_pkg: shared types for the TDM PCM receive path.
// FIFO entries are packed {ch, s} with s in the low WORD_W bits.
package pcm_tdm_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    GAP
  } rx_state_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pcm_tdm_rx_if.sv
// pcm_tdm_rx_if: received code + channel on a valid/ready handshake.
// master drives the word, slave returns ready.
interface pcm_tdm_rx_if
  import pcm_tdm_pkg::*;
#(
  parameter int CH_W = 5
);

  logic [WORD_W-1:0] s;
  logic [CH_W-1:0]   ch;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s,
    output ch,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s,
    input  ch,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/pcm_sync_fifo.sv
// pcm_sync_fifo: DEPTH x WIDTH synchronous FIFO, head entry always
// presented from storage; push while full succeeds only with a pop.
module pcm_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/pcm_tdm_rx.sv
// pcm_tdm_rx: framed serial PCM deserializer feeding a small output FIFO.
// Define PCM_TDM_FRAME_CHECK_EN to enable the frame-slip counter.
module pcm_tdm_rx
  import pcm_tdm_pkg::*;
#(
  parameter int NUM_CH     = 32,
  parameter int CH_W       = 5,
  parameter int FIFO_DEPTH = 4
`ifdef PCM_TDM_FRAME_CHECK_EN
  ,
  parameter int FRAME_BITS = NUM_CH * WORD_W
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pcm_bit_en,
  input  logic       fs,
  input  logic       pcm_din,
  pcm_tdm_rx_if.master rx,
  output logic       ovf,
  output logic [7:0] slip_cnt
);

  localparam int EW = CH_W + WORD_W;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  rx_state_t         state;
  logic [2:0]        bit_cnt;
  logic [CH_W-1:0]   ch_cnt;
  logic [6:0]        shift;
  logic              push;
  logic [CH_W-1:0]   push_ch;
  logic [WORD_W-1:0] push_s;
  logic [EW-1:0]     head;
  logic              full;
  logic              empty;
  logic              pop;

`ifdef PCM_TDM_FRAME_CHECK_EN
  localparam bit TIGHT = (FRAME_BITS == NUM_CH * WORD_W);
  logic       gap_first;
  logic [7:0] slip_q;
  assign slip_cnt = slip_q;
`else
  assign slip_cnt = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HUNT;
      bit_cnt <= '0;
      ch_cnt  <= '0;
      shift   <= '0;
      push    <= 1'b0;
      push_ch <= '0;
      push_s  <= '0;
`ifdef PCM_TDM_FRAME_CHECK_EN
      gap_first <= 1'b0;
      slip_q    <= '0;
`endif
    end else begin
      push <= 1'b0;
      if (pcm_bit_en) begin
        unique case (state)
          HUNT, GAP: begin
`ifdef PCM_TDM_FRAME_CHECK_EN
            if (state == GAP) begin
              gap_first <= 1'b0;
              if (fs && !gap_first && TIGHT)
                slip_q <= sat_inc8(slip_q);
            end
`endif
            if (fs) begin
              shift   <= {6'd0, pcm_din};
              bit_cnt <= 3'd1;
              ch_cnt  <= '0;
              state   <= SYNC;
            end
          end
          SYNC: begin
            if (fs) begin
              // premature frame sync: drop partial word, restart at ch0
              shift   <= {6'd0, pcm_din};
              bit_cnt <= 3'd1;
              ch_cnt  <= '0;
`ifdef PCM_TDM_FRAME_CHECK_EN
              slip_q  <= sat_inc8(slip_q);
`endif
            end else begin
              shift <= {shift[5:0], pcm_din};
              if (bit_cnt == 3'd7) begin
                push    <= 1'b1;
                push_ch <= ch_cnt;
                push_s  <= {shift, pcm_din};
                bit_cnt <= 3'd0;
                if (ch_cnt == LAST_CH) begin
                  state <= GAP;
`ifdef PCM_TDM_FRAME_CHECK_EN
                  gap_first <= 1'b1;
`endif
                end else begin
                  ch_cnt <= ch_cnt + CH_W'(1);
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign pop = !empty && rx.s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (push && full && !pop) begin
      ovf <= 1'b1;
    end
  end

  pcm_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data({push_ch, push_s}),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign rx.s       = head[WORD_W-1:0];
  assign rx.ch      = head[EW-1:WORD_W];
  assign rx.s_valid = !empty;

endmodule

// File: tb/tb_pcm_tdm_rx.sv
// tb_pcm_tdm_rx: scoreboard bench for pcm_tdm_rx.
// Frames are generated at slot level; expected words queue per slot.
module tb_pcm_tdm_rx;

  localparam int NUM_CH = 32;
  localparam int CH_W   = 5;
  localparam int DEPTH  = 4;

  logic       clk;
  logic       reset;
  logic       pcm_bit_en;
  logic       fs;
  logic       pcm_din;
  logic       ovf;
  logic [7:0] slip_cnt;

  pcm_tdm_rx_if #(.CH_W(CH_W)) bus ();

  pcm_tdm_rx #(
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pcm_bit_en(pcm_bit_en),
    .fs        (fs),
    .pcm_din   (pcm_din),
    .rx        (bus),
    .ovf       (ovf),
    .slip_cnt  (slip_cnt)
  );

  logic [CH_W+7:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int idle_max = 2;
  bit rand_ready = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog timeout chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (!reset && bus.s_valid && bus.s_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard unexpected word ch=%0d s=%h",
                 bus.ch, bus.s);
      end else begin
        logic [CH_W+7:0] e;
        e = exp_q.pop_front();
        if ({bus.ch, bus.s} !== e) begin
          n_fail++;
          $display("FAIL scoreboard got ch=%0d s=%h want ch=%0d s=%h",
                   bus.ch, bus.s, e[CH_W+7:8], e[7:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #2;
      bus.s_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      pcm_bit_en = 0;
      fs = 1'($urandom);
      pcm_din = 1'($urandom);
    end
  endtask

  task automatic send_bit(input bit f, input bit d);
    idle($urandom_range(0, idle_max));
    @(posedge clk);
    #2;
    pcm_bit_en = 1;
    fs = f;
    pcm_din = d;
  endtask

  task automatic send_word(input bit first, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(first && i == 7, w[i]);
  endtask

  task automatic send_frame(input int nfull, input int part,
                            input int pad, input bit fixed);
    for (int k = 0; k < nfull; k++) begin
      logic [7:0] v;
      v = fixed ? (8'(k) ^ 8'h55) : 8'($urandom);
      send_word(k == 0, v);
      exp_q.push_back({CH_W'(k), v});
    end
    for (int b = 0; b < part; b++)
      send_bit(nfull == 0 && b == 0, 1'($urandom));
    for (int b = 0; b < pad; b++) send_bit(0, 1'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1;
    pcm_bit_en = 0;
    repeat (3) @(posedge clk);
    #2;
    reset = 0;
    exp_q.delete();
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    idle(4);
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] w [6];
    reset = 1;
    pcm_bit_en = 0;
    fs = 0;
    pcm_din = 0;
    bus.s_ready = 0;
    do_reset();
    #1;
    chk("rst_valid", bus.s_valid, 0);
    chk("rst_s", bus.s, 0);
    chk("rst_ch", bus.ch, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_slip", slip_cnt, 0);

    bus.s_ready = 1;
    for (int i = 0; i < 40; i++) send_bit(0, 1);
    idle(10);
    chk("hunt_quiet", bus.s_valid, 0);

    idle_max = 0;
    do_reset();
    bus.s_ready = 1;
    exp_q.push_back({CH_W'(0), 8'hA5});
    send_word(1, 8'hA5);
    @(posedge clk);
    #1 chk("lat_a5_early", bus.s_valid, 0);
    #1 pcm_bit_en = 0;
    @(posedge clk);
    #1 chk("lat_a5_valid", bus.s_valid, 1);
    chk("lat_a5_s", bus.s, 8'hA5);
    chk("lat_a5_ch", bus.ch, 0);
    @(posedge clk);
    #1 chk("lat_a5_one", bus.s_valid, 0);
    exp_q.push_back({CH_W'(1), 8'h3C});
    send_word(0, 8'h3C);
    @(posedge clk);
    #1 chk("lat_3c_early", bus.s_valid, 0);
    #1 pcm_bit_en = 0;
    @(posedge clk);
    #1 chk("lat_3c_s", {bus.s_valid, bus.ch, bus.s}, {1'b1, 5'd1, 8'h3C});
    @(posedge clk);
    #1 chk("lat_3c_one", bus.s_valid, 0);
    drain("drain_pair");

    idle_max = 1;
    do_reset();
    send_frame(NUM_CH, 0, 16, 1);
    send_frame(2, 0, 0, 1);
    drain("drain_full_frame");
    chk("full_frame_slip", slip_cnt, 0);

    do_reset();
    send_frame(5, 3, 0, 0);
    send_frame(NUM_CH, 0, 0, 0);
    drain("drain_resync");
`ifdef PCM_TDM_FRAME_CHECK_EN
    chk("resync_slip", slip_cnt, 1);
`else
    chk("resync_slip", slip_cnt, 0);
`endif

    do_reset();
    bus.s_ready = 0;
    for (int k = 0; k < 6; k++) begin
      w[k] = 8'($urandom);
      send_word(k == 0, w[k]);
      if (k < DEPTH) exp_q.push_back({CH_W'(k), w[k]});
    end
    idle(3);
    chk("ovf_set", ovf, 1);
    chk("ovf_hold_a", {bus.s_valid, bus.ch, bus.s}, {1'b1, exp_q[0]});
    idle(5);
    chk("ovf_hold_b", {bus.s_valid, bus.ch, bus.s}, {1'b1, exp_q[0]});
    bus.s_ready = 1;
    drain("drain_ovf");
    chk("ovf_sticky", ovf, 1);
    chk("ovf_empty", bus.s_valid, 0);

    do_reset();
    chk("ovf_cleared", ovf, 0);
    bus.s_ready = 0;
    for (int k = 0; k < 5; k++) begin
      w[k] = 8'($urandom);
      exp_q.push_back({CH_W'(k), w[k]});
      if (k < 4) begin
        send_word(k == 0, w[k]);
      end else begin
        send_word(0, w[k]);
        @(posedge clk);
        #2;
        pcm_bit_en = 0;
        bus.s_ready = 1;
        @(posedge clk);
        #2;
        bus.s_ready = 0;
      end
    end
    idle(3);
    chk("pushpop_ovf", ovf, 0);
    bus.s_ready = 1;
    drain("drain_pushpop");

    do_reset();
    bus.s_ready = 0;
    send_frame(2, 3, 0, 0);
    idle(3);
    chk("pre_rst_valid", bus.s_valid, 1);
    do_reset();
    #1;
    chk("midrst_valid", bus.s_valid, 0);
    chk("midrst_ovf", ovf, 0);
    bus.s_ready = 1;
    send_word(0, 8'hFF);
    idle(5);
    send_frame(2, 0, 0, 0);
    drain("drain_after_rst");

    do_reset();
    idle_max = 3;
    rand_ready = 1;
    for (int f = 0; f < 12; f++) begin
      int nf;
      nf = $urandom_range(1, NUM_CH);
      send_frame(nf, (nf < NUM_CH) ? $urandom_range(0, 7) : 0,
                 (nf == NUM_CH) ? $urandom_range(0, 12) : 0, 0);
    end
    send_frame(1, 0, 0, 0);
    drain("drain_random");
    rand_ready = 0;
    bus.s_ready = 1;
    chk("random_ovf", ovf, 0);

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
